// File: rtl/axi_chan_cdc_src.sv
// Source (write) side of an asynchronous AXI channel FIFO: owns the slot storage,
// the Gray-coded write pointer and the read-pointer synchronizer.
module axi_chan_cdc_src #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned LogDepth   = 3,
  parameter int unsigned SyncStages = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [DataWidth-1:0]                src_data_i,
  input  logic                                src_valid_i,
  output logic                                src_ready_o,
  output logic [(2**LogDepth)*DataWidth-1:0]  async_data_o,
  output logic [LogDepth:0]                   async_wptr_o,
  input  logic [LogDepth:0]                   async_rptr_i,
  output logic [LogDepth:0]                   fill_o
);

  localparam int unsigned Depth = 2**LogDepth;

  typedef logic [LogDepth:0] ptr_t;

  // Gray full pattern: top two bits inverted relative to the read pointer.
  localparam ptr_t FullMask = ptr_t'(3) << (LogDepth - 1);

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[LogDepth] = g[LogDepth];
    for (int unsigned i = 0; i < LogDepth; i++) begin
      b[LogDepth-1-i] = b[LogDepth-i] ^ g[LogDepth-1-i];
    end
    return b;
  endfunction

  ptr_t                 wbin_q, wbin_d;
  ptr_t                 wptr_q, wptr_d;
  ptr_t                 fill_q, fill_d;
  ptr_t                 sync_q [SyncStages];
  ptr_t                 sync_d [SyncStages];
  logic [DataWidth-1:0] mem_q  [Depth];
  logic [DataWidth-1:0] mem_d  [Depth];

  ptr_t rsync;
  logic full;
  logic push;

  assign rsync        = sync_q[SyncStages-1];
  assign full         = (wptr_q == (rsync ^ FullMask));
  assign src_ready_o  = !full && !rst_i;
  assign push         = src_valid_i && src_ready_o;
  assign async_wptr_o = wptr_q;
  assign fill_o       = fill_q;

  always_comb begin
    wbin_d = wbin_q;
    mem_d  = mem_q;
    if (push) begin
      mem_d[wbin_q[LogDepth-1:0]] = src_data_i;
      wbin_d                      = wbin_q + ptr_t'(1);
    end
    wptr_d = wbin_d ^ (wbin_d >> 1);
    // Uses the post-write pointer so fill moves in the same cycle as async_wptr_o.
    fill_d = wbin_d - gray2bin(rsync);
  end

  always_comb begin
    sync_d[0] = async_rptr_i;
    for (int unsigned i = 1; i < SyncStages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    async_data_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      async_data_o[i*DataWidth +: DataWidth] = mem_q[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wbin_q <= '0;
      wptr_q <= '0;
      fill_q <= '0;
      for (int unsigned i = 0; i < SyncStages; i++) sync_q[i] <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wbin_q <= wbin_d;
      wptr_q <= wptr_d;
      fill_q <= fill_d;
      sync_q <= sync_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: tb/tb_axi_chan_cdc_src.sv
// Directed bench for axi_chan_cdc_src at DataWidth=8, LogDepth=3, SyncStages=2.
module tb_axi_chan_cdc_src;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  src_data_i;
  logic        src_valid_i;
  logic        src_ready_o;
  logic [63:0] async_data_o;
  logic [3:0]  async_wptr_o;
  logic [3:0]  async_rptr_i;
  logic [3:0]  fill_o;

  int checks = 0;
  int errors = 0;

  axi_chan_cdc_src #(
    .DataWidth (8),
    .LogDepth  (3),
    .SyncStages(2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .src_data_i  (src_data_i),
    .src_valid_i (src_valid_i),
    .src_ready_o (src_ready_o),
    .async_data_o(async_data_o),
    .async_wptr_o(async_wptr_o),
    .async_rptr_i(async_rptr_i),
    .fill_o      (fill_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [3:0]  fill_seq [8] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
  logic [3:0]  wrap_seq [16] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12,
                                 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8, 4'd0};
  logic [63:0] exp_data;
  logic [3:0]  prev_ptr;
  int          ready_n;
  int          fill_n;

  initial begin
    rst_i        = 1'b1;
    src_valid_i  = 1'b0;
    src_data_i   = '0;
    async_rptr_i = '0;

    // Reset state
    tick();
    tick();
    chk("rst_wptr", async_wptr_o, 0);
    chk("rst_ready", src_ready_o, 0);
    chk("rst_fill", fill_o, 0);
    chk("rst_data", async_data_o, 0);
    rst_i = 1'b0;
    #1;
    chk("rel_ready", src_ready_o, 1);
    tick();

    // Fill 8 beats back-to-back
    exp_data = '0;
    for (int k = 0; k < 8; k++) begin
      src_valid_i = 1'b1;
      src_data_i  = 8'h10 + 8'(k);
      exp_data[k*8 +: 8] = 8'h10 + 8'(k);
      tick();
      chk($sformatf("fill_wptr%0d", k), async_wptr_o, fill_seq[k]);
    end
    src_valid_i = 1'b0;
    chk("full_ready", src_ready_o, 0);
    chk("full_fill", fill_o, 8);
    chk("full_data", async_data_o, exp_data);

    // Stall while full
    src_valid_i = 1'b1;
    src_data_i  = 8'hAA;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall_wptr%0d", k), async_wptr_o, 12);
      chk($sformatf("stall_data%0d", k), async_data_o, exp_data);
    end
    src_valid_i = 1'b0;

    // Drain: reader at binary 3
    async_rptr_i = 4'b0010;
    ready_n = 0;
    fill_n  = 0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      if (ready_n == 0 && src_ready_o) ready_n = n;
      if (fill_n == 0 && fill_o == 4'd5) fill_n = n;
    end
    chk("drain_ready_lat", (ready_n >= 2 && ready_n <= 3), 1);
    chk("drain_fill_lat", (fill_n >= 2 && fill_n <= 3), 1);
    chk("drain_fill", fill_o, 5);
    src_valid_i = 1'b1;
    src_data_i  = 8'h55;
    tick();
    src_valid_i = 1'b0;
    chk("drain_slot0", async_data_o[7:0], 8'h55);
    chk("drain_slot1", async_data_o[15:8], 8'h11);
    chk("drain_wptr", async_wptr_o, 13);
    chk("drain_fill2", fill_o, 6);

    // Reset again before the wrap test
    rst_i        = 1'b1;
    async_rptr_i = '0;
    #1;
    chk("rst2_wptr", async_wptr_o, 0);
    tick();
    rst_i = 1'b0;
    tick();

    // Wrap: 16 writes with the reader echoing the write pointer
    prev_ptr = async_wptr_o;
    for (int k = 0; k < 16; k++) begin
      src_valid_i = 1'b1;
      src_data_i  = 8'h20 + 8'(k);
      tick();
      chk($sformatf("wrap_wptr%0d", k), async_wptr_o, wrap_seq[k]);
      chk($sformatf("wrap_1bit%0d", k), $countones(prev_ptr ^ async_wptr_o), 1);
      prev_ptr     = async_wptr_o;
      async_rptr_i = async_wptr_o;
      if (k == 8) chk("wrap_slot0_ovw", async_data_o[7:0], 8'h28);
    end
    src_valid_i = 1'b0;
    chk("wrap_end_wptr", async_wptr_o, 0);
    chk("wrap_data", async_data_o, 64'h2f2e2d2c2b2a2928);
    tick();
    tick();
    tick();
    chk("wrap_fill", fill_o, 0);
    chk("wrap_ready", src_ready_o, 1);

    // Async reset mid-burst
    for (int k = 0; k < 3; k++) begin
      src_valid_i = 1'b1;
      src_data_i  = 8'h60 + 8'(k);
      tick();
    end
    chk("burst_wptr", async_wptr_o, 2);
    src_data_i = 8'h63;
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_wptr", async_wptr_o, 0);
    chk("arst_ready", src_ready_o, 0);
    chk("arst_fill", fill_o, 0);
    chk("arst_data", async_data_o, 0);
    src_valid_i  = 1'b0;
    async_rptr_i = '0;
    tick();
    rst_i = 1'b0;
    #1;
    chk("arst_rel_ready", src_ready_o, 1);
    src_valid_i = 1'b1;
    src_data_i  = 8'h77;
    tick();
    src_valid_i = 1'b0;
    chk("arst_next_wptr", async_wptr_o, 1);
    chk("arst_next_data", async_data_o, 64'h77);
    chk("arst_next_fill", fill_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
